// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, I-cache request FSM, hold buffer and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN: an odd PC in FETCH raises a fetch error instead of issuing a read.
module fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        imem_err,
  output logic [15:0] instr,
  output logic [15:0] PC,
  output logic        NOP_mech,
  output logic        IDF_err,
  output logic        fetch_busy
);

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_SQUASH, S_HOLD, S_HALTED} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        nop;
    logic        err;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{instr: NOP_INSTR, pc: RESET_PC, nop: 1'b1, err: 1'b0};

  state_t      state;
  logic [15:0] pc_q;
  logic [15:0] sq_addr_q;
  ifid_t       ifid_q;
  ifid_t       hold_q;

  logic  misaligned;
  logic  issuing;
  logic  rd_done;
  logic  outstanding;
  ifid_t fetched;
  ifid_t bubble;
  ifid_t align_fault;
  logic  unused_imem_stall;

  // A word stops fetch when it carries an error or is a HALT (opcode 00000).
  function automatic logic halts(input ifid_t e);
    return e.err || (e.instr[15:11] == 5'b00000);
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (state == S_FETCH) && pc_q[0];
`else
  assign misaligned = 1'b0;
`endif

  assign issuing = (state == S_FETCH) || (state == S_WAIT) || (state == S_SQUASH);
  // NOTE: imem_rd is gated by rst so no request reaches the cache while reset is held.
  assign imem_rd     = issuing && !misaligned && !rst;
  assign imem_addr   = (state == S_SQUASH) ? sq_addr_q : pc_q;
  assign rd_done     = imem_rd && imem_done;
  assign outstanding = imem_rd && !imem_done;
  assign fetch_busy  = (state == S_WAIT) || (state == S_SQUASH) ||
                       ((state == S_FETCH) && outstanding);

  assign fetched     = '{instr: imem_data, pc: pc_q + 16'd2, nop: 1'b0, err: imem_err};
  assign bubble      = '{instr: NOP_INSTR, pc: ifid_q.pc, nop: 1'b1, err: 1'b0};
  assign align_fault = '{instr: NOP_INSTR, pc: pc_q + 16'd2, nop: 1'b0, err: 1'b1};

  // The cache's own busy flag is informational; done/err fully describe completion.
  assign unused_imem_stall = imem_stall;

  // NOTE: every register here uses non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      sq_addr_q <= RESET_PC;
      ifid_q    <= IFID_RESET;
      hold_q    <= IFID_RESET;
    end else if (redirect) begin
      // Redirect wins in every state; an in-flight read must still drain before refetching.
      pc_q      <= redirect_pc;
      ifid_q    <= bubble;
      hold_q    <= IFID_RESET;
      sq_addr_q <= imem_addr;
      state     <= outstanding ? S_SQUASH : S_FETCH;
    end else begin
      unique case (state)
        S_FETCH, S_WAIT: begin
          if (misaligned) begin
            if (!stall_in) begin
              ifid_q <= align_fault;
              state  <= S_HALTED;
            end
          end else if (rd_done) begin
            pc_q <= pc_q + 16'd2;
            if (!stall_in) begin
              ifid_q <= fetched;
              state  <= halts(fetched) ? S_HALTED : S_FETCH;
            end else begin
              hold_q <= fetched;
              state  <= S_HOLD;
            end
          end else begin
            state <= S_WAIT;
            if (!stall_in) ifid_q <= bubble;
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            ifid_q <= hold_q;
            state  <= halts(hold_q) ? S_HALTED : S_FETCH;
          end
        end
        S_SQUASH: begin
          if (!stall_in) ifid_q <= bubble;
          if (rd_done) state <= S_FETCH;
        end
        S_HALTED: begin
          if (!stall_in) ifid_q <= bubble;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign instr    = ifid_q.instr;
  assign PC       = ifid_q.pc;
  assign NOP_mech = ifid_q.nop;
  assign IDF_err  = ifid_q.err;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus random stall/redirect/miss traffic,
// compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_stall;
  logic        imem_err;
  logic [15:0] instr;
  logic [15:0] PC;
  logic        NOP_mech;
  logic        IDF_err;
  logic        fetch_busy;

  fetch dut (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_done  (imem_done),
    .imem_stall (imem_stall),
    .imem_err   (imem_err),
    .instr      (instr),
    .PC         (PC),
    .NOP_mech   (NOP_mech),
    .IDF_err    (IDF_err),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: what the pipeline register should hold and what the stage is doing.
  logic [15:0] m_pc, m_drain_addr;
  bit          m_halted, m_holding, m_draining, m_missing;
  logic [15:0] e_instr, e_pc;
  bit          e_nop, e_err;
  logic [15:0] h_instr, h_pc;
  bit          h_err;

  // Cache model and stimulus knobs.
  bit          req_active;
  int          lat_left;
  int          forced_lat[$];
  bit          rand_mode;
  bit          halt_en;
  logic [15:0] halt_at;
  bit          k_stall, k_redir;
  logic [15:0] k_rpc;

  function automatic logic [15:0] word_for(input logic [15:0] a);
    logic [15:0] w;
    if (halt_en && a == halt_at) return 16'h0000;
    if (!rand_mode) return 16'h4000 | (a >> 1);
    w = 16'($urandom);
    if ($urandom_range(0, 29) == 0) w[15:11] = 5'd0;
    else if (w[15:11] == 5'd0) w[15:11] = 5'd9;
    return w;
  endfunction

  function automatic bit is_stop(input logic [15:0] w, input bit err);
    return err || (w[15:11] == 5'd0);
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_drain_addr = 16'h0000;
    m_halted = 0; m_holding = 0; m_draining = 0; m_missing = 0;
    e_instr = NOP; e_pc = 16'h0000; e_nop = 1; e_err = 0;
    h_instr = NOP; h_pc = 16'h0000; h_err = 0;
    req_active = 0; lat_left = 0;
  endtask

  task automatic put_bubble();
    e_instr = NOP; e_nop = 1; e_err = 0;
  endtask

  task automatic cycle();
    bit          fetching, odd, rd_e, busy_e, done, err, outstanding;
    logic [15:0] addr_e, data;
    @(negedge clk);
    fetching = !(m_halted || m_holding || m_draining || m_missing);
    odd = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    odd = fetching && m_pc[0];
`endif
    rd_e   = !m_halted && !m_holding && !odd;
    addr_e = m_draining ? m_drain_addr : m_pc;
    done = 0; err = 0; data = 16'($urandom);
    if (rd_e) begin
      if (!req_active) begin
        req_active = 1;
        if (forced_lat.size() > 0) lat_left = forced_lat.pop_front();
        else if (rand_mode && $urandom_range(0, 2) == 0) lat_left = $urandom_range(1, 4);
        else lat_left = 0;
      end
      if (lat_left == 0) begin
        done = 1; req_active = 0;
        data = word_for(addr_e);
        err  = rand_mode && ($urandom_range(0, 59) == 0);
      end else begin
        lat_left--;
      end
    end
    stall_in    = k_stall;
    redirect    = k_redir;
    redirect_pc = k_rpc;
    imem_done   = done;
    imem_data   = data;
    imem_err    = done ? err : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b0);
    imem_stall  = rd_e && !done;
    #1;
    check("instr", instr, e_instr);
    check("PC", PC, e_pc);
    check("NOP_mech", NOP_mech, e_nop);
    check("IDF_err", IDF_err, e_err);
    check("imem_rd", imem_rd, rd_e);
    if (rd_e) check("imem_addr", imem_addr, addr_e);
    busy_e = m_draining || m_missing || (fetching && rd_e && !done);
    check("fetch_busy", fetch_busy, busy_e);

    // Advance the model by one clock.
    if (k_redir) begin
      outstanding = rd_e && !done;
      put_bubble();
      m_holding = 0; m_missing = 0; m_halted = 0;
      if (outstanding) m_drain_addr = addr_e;
      m_draining = outstanding;
      m_pc = k_rpc;
    end else if (m_halted) begin
      if (!k_stall) put_bubble();
    end else if (m_holding) begin
      if (!k_stall) begin
        e_instr = h_instr; e_pc = h_pc; e_nop = 0; e_err = h_err;
        m_holding = 0;
        m_halted = is_stop(h_instr, h_err);
      end
    end else if (m_draining) begin
      if (!k_stall) put_bubble();
      if (done) m_draining = 0;
    end else if (odd) begin
      if (!k_stall) begin
        e_instr = NOP; e_pc = m_pc + 16'd2; e_nop = 0; e_err = 1;
        m_halted = 1;
      end
    end else if (done) begin
      m_missing = 0;
      m_pc = m_pc + 16'd2;
      if (!k_stall) begin
        e_instr = data; e_pc = m_pc; e_nop = 0; e_err = err;
        m_halted = is_stop(data, err);
      end else begin
        h_instr = data; h_pc = m_pc; h_err = err;
        m_holding = 1;
      end
    end else begin
      m_missing = 1;
      if (!k_stall) put_bubble();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; stall_in = 0; redirect = 0; imem_done = 0; imem_err = 0; imem_stall = 0;
    k_stall = 0; k_redir = 0; halt_en = 0;
    forced_lat.delete();
    @(negedge clk);
    #1;
    check("rst_instr", instr, NOP);
    check("rst_PC", PC, 16'h0000);
    check("rst_NOP_mech", NOP_mech, 1'b1);
    check("rst_IDF_err", IDF_err, 1'b0);
    check("rst_imem_rd", imem_rd, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall_in = 0; redirect = 0; redirect_pc = 16'h0000;
    imem_data = 16'h0000; imem_done = 0; imem_err = 0; imem_stall = 0;
    rand_mode = 0; halt_en = 0; halt_at = 16'h0000;
    k_stall = 0; k_redir = 0; k_rpc = 16'h0000;
    model_reset();

    // Back-to-back hits from reset.
    do_reset();
    repeat (8) cycle();

    // 3-cycle miss at 0x0004.
    do_reset();
    forced_lat.push_back(0); forced_lat.push_back(0); forced_lat.push_back(3);
    repeat (10) cycle();

    // Two stalled cycles landing on a hit.
    do_reset();
    repeat (2) cycle();
    k_stall = 1; repeat (2) cycle();
    k_stall = 0; repeat (4) cycle();

    // Redirect to 0x0100 in the middle of a 4-cycle miss.
    do_reset();
    cycle();
    forced_lat.push_back(4);
    repeat (2) cycle();
    k_redir = 1; k_rpc = 16'h0100; cycle();
    k_redir = 0; repeat (8) cycle();

    // HALT at 0x0006, then a redirect to 0x0040 resumes.
    do_reset();
    halt_en = 1; halt_at = 16'h0006;
    repeat (6) cycle();
    halt_en = 0;
    k_redir = 1; k_rpc = 16'h0040; cycle();
    k_redir = 0; repeat (4) cycle();

    // Redirect to an odd target.
    do_reset();
    cycle();
    k_redir = 1; k_rpc = 16'h0033; cycle();
    k_redir = 0; repeat (4) cycle();

    // Asynchronous reset in the middle of a miss.
    do_reset();
    forced_lat.push_back(5);
    repeat (3) cycle();
    @(negedge clk);
    imem_done = 0; imem_err = 0;
    #2 rst = 1;
    #1;
    check("amid_instr", instr, NOP);
    check("amid_NOP_mech", NOP_mech, 1'b1);
    check("amid_imem_rd", imem_rd, 1'b0);
    check("amid_fetch_busy", fetch_busy, 1'b0);
    do_reset();
    repeat (4) cycle();

    // Random traffic: stalls, redirects, misses, errors and halts.
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      k_stall = ($urandom_range(0, 3) == 0);
      k_redir = ($urandom_range(0, 11) == 0);
      k_rpc   = 16'($urandom);
      if ($urandom_range(0, 9) != 0) k_rpc[0] = 1'b0;
      cycle();
    end
    rand_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
